// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Issue stage in front of a 16-bit combinational ALU. Holds a small
//   register file and accepts one command at a time over valid/ready. Each
//   accepted op takes three cycles: IDLE (accept), EXEC (ALU inputs stable,
//   result captured) and WB (done pulse, writeback, flag update). The stored
//   carry flag can be chosen as the next op's carry-in for multi-word math.
//
// Optional build macro:
//   REG0_ZERO_EN - register 0 reads as zero; loads and writebacks to it are
//                  dropped (done pulse and flags still update).
//
// Ports:
//   i_clk, i_rst_n        clock (rising edge) and synchronous active-low reset
//   i_cmd_*, o_cmd_ready  command handshake and fields
//   i_ld_*                direct register load strobe, usable in any state
//   o_alu_*               operand/control drive to the ALU (held outside EXEC)
//   i_alu_*               result, carry_out and compare from the ALU
//   o_done_valid/_data    one-cycle writeback pulse and written value
//   o_flag_*              carry, compare and zero of the last completed op
module alu_op_sequencer #(
  parameter int DATA_W    = 16,
  parameter int REG_COUNT = 8,
  parameter int ADDR_W    = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [3:0]        i_cmd_select,
  input  logic              i_cmd_mode,
  input  logic [ADDR_W-1:0] i_cmd_src_a,
  input  logic [ADDR_W-1:0] i_cmd_src_b,
  input  logic [ADDR_W-1:0] i_cmd_dst,
  input  logic              i_cmd_use_carry,
  input  logic              i_cmd_carry,
  input  logic              i_ld_valid,
  input  logic [ADDR_W-1:0] i_ld_addr,
  input  logic [DATA_W-1:0] i_ld_data,
  output logic [DATA_W-1:0] o_alu_in_a,
  output logic [DATA_W-1:0] o_alu_in_b,
  output logic [3:0]        o_alu_select,
  output logic              o_alu_mode,
  output logic              o_alu_carry_in,
  input  logic [DATA_W-1:0] i_alu_result,
  input  logic              i_alu_carry_out,
  input  logic              i_alu_compare,
  output logic              o_done_valid,
  output logic [DATA_W-1:0] o_done_data,
  output logic              o_flag_carry,
  output logic              o_flag_compare,
  output logic              o_flag_zero
);

`ifdef REG0_ZERO_EN
  localparam logic REG0_ZERO = 1'b1;
`else
  localparam logic REG0_ZERO = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_WB   = 2'b10
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_ready;
  logic                w_ready_nxt;
  logic [DATA_W-1:0]   r_regs [REG_COUNT];
  logic [DATA_W-1:0]   r_op_a;
  logic [DATA_W-1:0]   r_op_b;
  logic [3:0]          r_sel;
  logic                r_mode;
  logic                r_cin;
  logic [ADDR_W-1:0]   r_dst;
  logic [DATA_W-1:0]   r_res;
  logic                r_co;
  logic                r_cmp;
  logic                r_done;
  logic                r_flag_carry;
  logic                r_flag_compare;
  logic                r_flag_zero;
  logic [DATA_W-1:0]   w_rd_a;
  logic [DATA_W-1:0]   w_rd_b;
  logic                w_accept;
  logic                w_wb_en;
  logic                w_ld_en;

  // r_ready is only ever high in IDLE, so it alone qualifies acceptance
  assign w_accept = i_cmd_valid && r_ready;
  assign w_wb_en  = (r_state == ST_WB) && !(REG0_ZERO && (r_dst == {ADDR_W{1'b0}}));
  assign w_ld_en  = i_ld_valid && !(REG0_ZERO && (i_ld_addr == {ADDR_W{1'b0}}));

  // Next-state and next-ready decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_EXEC;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_EXEC: w_state_nxt = ST_WB;
      ST_WB:   w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    w_ready_nxt = (w_state_nxt == ST_IDLE);
  end

  // Register-file read ports for the operands of an arriving command
  always_comb begin
    w_rd_a = r_regs[i_cmd_src_a];
    w_rd_b = r_regs[i_cmd_src_b];
    if (REG0_ZERO && (i_cmd_src_a == {ADDR_W{1'b0}})) begin
      w_rd_a = {DATA_W{1'b0}};
    end else begin
      w_rd_a = r_regs[i_cmd_src_a];
    end
    if (REG0_ZERO && (i_cmd_src_b == {ADDR_W{1'b0}})) begin
      w_rd_b = {DATA_W{1'b0}};
    end else begin
      w_rd_b = r_regs[i_cmd_src_b];
    end
  end

  // State register and ready flag (ready stays low while in reset)
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= w_ready_nxt;
    end
  end

  // Register file: writeback is ordered after the load so it wins a collision
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        r_regs[i] <= {DATA_W{1'b0}};
      end
    end else begin
      if (w_ld_en) begin
        r_regs[i_ld_addr] <= i_ld_data;
      end
      if (w_wb_en) begin
        r_regs[r_dst] <= r_res;
      end
    end
  end

  // Latch operands and controls on acceptance; they double as ALU drive
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_op_a <= {DATA_W{1'b0}};
      r_op_b <= {DATA_W{1'b0}};
      r_sel  <= 4'b0000;
      r_mode <= 1'b0;
      r_cin  <= 1'b0;
      r_dst  <= {ADDR_W{1'b0}};
    end else if (w_accept) begin
      r_op_a <= w_rd_a;
      r_op_b <= w_rd_b;
      r_sel  <= i_cmd_select;
      r_mode <= i_cmd_mode;
      r_cin  <= i_cmd_use_carry ? r_flag_carry : i_cmd_carry;
      r_dst  <= i_cmd_dst;
    end
  end

  // Capture the ALU response at the end of EXEC and raise the WB pulse
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_res  <= {DATA_W{1'b0}};
      r_co   <= 1'b0;
      r_cmp  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == ST_EXEC);
      if (r_state == ST_EXEC) begin
        r_res <= i_alu_result;
        r_co  <= i_alu_carry_out;
        r_cmp <= i_alu_compare;
      end
    end
  end

  // Status flags commit together with the writeback
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_flag_carry   <= 1'b0;
      r_flag_compare <= 1'b0;
      r_flag_zero    <= 1'b0;
    end else if (r_state == ST_WB) begin
      r_flag_carry   <= r_co;
      r_flag_compare <= r_cmp;
      r_flag_zero    <= (r_res == {DATA_W{1'b0}});
    end
  end

  assign o_cmd_ready    = r_ready;
  assign o_alu_in_a     = r_op_a;
  assign o_alu_in_b     = r_op_b;
  assign o_alu_select   = r_sel;
  assign o_alu_mode     = r_mode;
  assign o_alu_carry_in = r_cin;
  assign o_done_valid   = r_done;
  assign o_done_data    = r_res;
  assign o_flag_carry   = r_flag_carry;
  assign o_flag_compare = r_flag_compare;
  assign o_flag_zero    = r_flag_zero;

endmodule
